fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RV32I pipeline. It owns the PC, issues requests to instruction memory over a request/grant/response handshake and absorbs variable memory latency in a 2-entry fetch buffer. It drives the IF/ID pipeline register. It consumes the hazard unit's PC-enable and IF/ID-stall controls and the EX-stage branch/jump redirect, and feeds the ID stage with instruction, PC and valid.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_pc_en  input  1  hazard-unit PC enable; 0 = stall
- i_IF_ID_stall  input  1  hazard-unit IF/ID hold; stall = i_IF_ID_stall | ~i_pc_en
- i_redirect  input  1  EX-stage taken branch/jump
- i_redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
- o_imem_req  output  1  fetch request valid
- o_imem_addr  output  32  fetch address (= PC)
- i_imem_gnt  input  1  request accepted this cycle
- i_imem_rvalid  input  1  response valid; responses return in order, ≥1 cycle after grant
- i_imem_rdata  input  32  fetched instruction
- o_ID_inst  output  32  IF/ID instruction
- o_ID_pc  output  32  IF/ID PC
- o_ID_valid  output  1  IF/ID holds a real instruction

## Operation
- **FSM states:** BOOT, RUN, FLUSH.
  - BOOT: first cycle out of reset, no request, then RUN.
  - RUN → FLUSH: on redirect when stale responses are outstanding.
  - FLUSH → RUN: when the kill count reaches 0.
- **Request rule:**
  - In RUN, o_imem_req = (outstanding + buf_count < 2) & ~i_redirect.
  - No requests in BOOT or FLUSH.
  - On req & gnt, PC += 4 and outstanding++.
- **Response:**
  - rvalid with kill count > 0 decrements kill and is discarded.
  - Otherwise, rvalid pushes {rdata, pc_of_request} into the buffer; outstanding--.
  - A PC queue tracks request addresses, depth 2.
  - The capacity rule guarantees space, so the buffer never overflows.
- **IF/ID update:**
  - When not stalled, pop the buffer head into IF/ID, valid=1.
  - Bypass: if the buffer is empty and a live rvalid arrives, load it directly into IF/ID.
  - If nothing is available, load a bubble: NOP 32'h0000_0013, valid=0.
  - When stalled, IF/ID and buffer head hold.
- **Redirect** (wins over every other event):
  - PC ← {i_redirect_pc[31:2],2'b00}.
  - Buffer cleared.
  - IF/ID ← bubble, even when stalled.
  - Kill count ← outstanding after this cycle's gnt/rvalid are counted; a same-cycle grant is stale, and a same-cycle rvalid is discarded.
  - Next state is FLUSH if kill > 0, else RUN.
- **Redirect in FLUSH:** updates PC; the kill count continues counting the remaining stale responses.
- **Arithmetic:**
  - PC adds wrap modulo 2^32.
  - outstanding and buf_count are 2-bit values with invariant sum ≤ 2.

## Timing
- **Reset values:**
  - PC=RESET_PC, state=BOOT, buffer empty, outstanding=0, kill=0.
  - o_imem_req=0, o_imem_addr=RESET_PC.
  - o_ID_inst=32'h0000_0013, o_ID_pc=0, o_ID_valid=0.
- **Combinational outputs:** o_imem_req and o_imem_addr are combinational from registered state and i_redirect.
- **Latency:**
  - First request appears in cycle 1 after reset release.
  - Live rvalid in cycle N gives o_ID_valid=1 in N+1 (bypass, not stalled).
- **Redirect:**
  - Asserted in cycle N: o_ID_valid=0 in N+1.
  - First request to the target in N+1 if no stale responses are outstanding.
- **Asynchronous reset mid-operation:** all state clears immediately. Responses arriving after reset release with outstanding=0 are ignored.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds 32-bit saturating counters o_perf_bubbles (cycles IF/ID loaded a bubble while not stalled) and o_perf_redirects (redirect count).
  - Both counters reset to 0.
- Undefined: both ports exist but are tied to 0; no counter flops.

## Structure
- **fetch_pkg:**
  - NOP_INST = 32'h0000_0013.
  - FETCH_BUF_DEPTH = 2.
  - fetch_state_e {BOOT, RUN, FLUSH}.
  - Typedef fetch_entry_t {inst[31:0], pc[31:0]}.
- **Sub-module fetch_buffer:**
  - 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, clear, head, count.
  - Clear has priority over push and pop.

## Test plan
- Reset release, memory grants every cycle with 1-cycle rvalid, no stall → addresses 0,4,8,...; o_ID_valid=1 from cycle 3 with o_ID_pc 0,4,8 in order.
- Stall 3 cycles (i_pc_en=0, i_IF_ID_stall=1) with both responses returned → o_ID_pc held; buffer full, o_imem_req=0; after release, PCs continue with no gaps or duplicates.
- 2 requests outstanding with 4-cycle latency, redirect to 32'h100 → both stale responses dropped; FLUSH for their duration; next o_ID_pc=32'h100.
- Redirect coinciding with a grant and an rvalid → both treated as stale; o_ID_valid=0 next cycle; no wrong-path PC ever reaches ID.
- Redirect to 32'hFFFF_FFFE → fetch 32'hFFFF_FFFC, then 32'h0000_0000 (wrap).
- i_rst_n asserted while 2 requests outstanding → outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch entries pair an instruction word with the PC it was fetched from.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry synchronous FIFO of fetch entries; head is valid whenever count is non-zero.
// Clear wins over push/pop; a push into a full buffer is dropped unless a pop frees a slot.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'(FETCH_BUF_DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, fetches over req/gnt/rvalid, buffers two entries, drives IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating bubble/redirect counters; otherwise those ports read 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pc_en,
  input  logic        i_IF_ID_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ID_inst,
  output logic [31:0] o_ID_pc,
  output logic        o_ID_valid,
  output logic [31:0] o_perf_bubbles,
  output logic [31:0] o_perf_redirects
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [1:0]   outstanding;
  logic [1:0]   kill;
  logic [1:0]   out_after;
  logic [1:0]   kill_after;
  logic [2:0]   inflight;
  logic [1:0]   buf_count;
  fetch_entry_t buf_head;
  fetch_entry_t rsp_entry;
  logic [31:0]  pcq [2];
  logic         pcq_rd;
  logic         pcq_wr;
  logic         stall;
  logic         fire;
  logic         rsp_kill;
  logic         rsp_ok;
  logic         live;
  logic         bypass;
  logic         buf_push;
  logic         buf_pop;

  assign stall      = i_IF_ID_stall | ~i_pc_en;
  assign inflight   = {1'b0, outstanding} + {1'b0, buf_count};
  assign fire       = o_imem_req & i_imem_gnt;
  assign rsp_kill   = i_imem_rvalid & (kill != 2'd0);
  // A response only belongs to a live request if one is actually outstanding.
  assign rsp_ok     = i_imem_rvalid & (kill == 2'd0) & (outstanding != 2'd0);
  assign live       = rsp_ok & ~i_redirect;
  assign out_after  = outstanding + {1'b0, fire} - {1'b0, rsp_ok};
  assign kill_after = kill - {1'b0, rsp_kill};
  assign bypass     = live & ~stall & (buf_count == 2'd0);
  assign buf_push   = live & ~bypass;
  assign buf_pop    = ~i_redirect & ~stall & (buf_count != 2'd0);
  assign rsp_entry  = '{inst: i_imem_rdata, pc: pcq[pcq_rd]};

  fetch_buffer u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (buf_push),
    .data  (rsp_entry),
    .pop   (buf_pop),
    .clear (i_redirect),
    .head  (buf_head),
    .count (buf_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      FLUSH:   if (kill_after == 2'd0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    if (i_redirect) state_nxt = ((kill_after + out_after) != 2'd0) ? FLUSH : RUN;
  end

  always_comb begin
    o_imem_req  = (state == RUN) & (inflight < 3'd2) & ~i_redirect;
    o_imem_addr = pc;
  end

  // Requests still in flight at a redirect become kills; the PC queue only tracks live ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      kill        <= 2'd0;
      pcq[0]      <= '0;
      pcq[1]      <= '0;
      pcq_rd      <= 1'b0;
      pcq_wr      <= 1'b0;
      o_ID_inst   <= NOP_INST;
      o_ID_pc     <= '0;
      o_ID_valid  <= 1'b0;
    end else if (i_redirect) begin
      pc          <= align_pc(i_redirect_pc);
      outstanding <= 2'd0;
      kill        <= kill_after + out_after;
      pcq_rd      <= 1'b0;
      pcq_wr      <= 1'b0;
      o_ID_inst   <= NOP_INST;
      o_ID_pc     <= '0;
      o_ID_valid  <= 1'b0;
    end else begin
      outstanding <= out_after;
      kill        <= kill_after;
      if (fire) begin
        pc          <= pc + 32'd4;
        pcq[pcq_wr] <= pc;
        pcq_wr      <= ~pcq_wr;
      end
      if (rsp_ok) pcq_rd <= ~pcq_rd;
      if (!stall) begin
        if (buf_count != 2'd0) begin
          o_ID_inst  <= buf_head.inst;
          o_ID_pc    <= buf_head.pc;
          o_ID_valid <= 1'b1;
        end else if (bypass) begin
          o_ID_inst  <= rsp_entry.inst;
          o_ID_pc    <= rsp_entry.pc;
          o_ID_valid <= 1'b1;
        end else begin
          o_ID_inst  <= NOP_INST;
          o_ID_pc    <= '0;
          o_ID_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic bubble_load;
  assign bubble_load = ~stall & (i_redirect | ((buf_count == 2'd0) & ~live));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_bubbles   <= '0;
      o_perf_redirects <= '0;
    end else begin
      if (bubble_load && (o_perf_bubbles != '1)) o_perf_bubbles <= o_perf_bubbles + 32'd1;
      if (i_redirect && (o_perf_redirects != '1)) o_perf_redirects <= o_perf_redirects + 32'd1;
    end
  end
`else
  assign o_perf_bubbles   = '0;
  assign o_perf_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus a program-order model of fetch and ID streams.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pc_en;
  logic        i_IF_ID_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_ID_inst;
  logic [31:0] o_ID_pc;
  logic        o_ID_valid;
  logic [31:0] o_perf_bubbles;
  logic [31:0] o_perf_redirects;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pc_en          (i_pc_en),
    .i_IF_ID_stall    (i_IF_ID_stall),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_gnt       (i_imem_gnt),
    .i_imem_rvalid    (i_imem_rvalid),
    .i_imem_rdata     (i_imem_rdata),
    .o_ID_inst        (o_ID_inst),
    .o_ID_pc          (o_ID_pc),
    .o_ID_valid       (o_ID_valid),
    .o_perf_bubbles   (o_perf_bubbles),
    .o_perf_redirects (o_perf_redirects)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] dq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_en = 1'b1;
  logic [31:0] exp_fetch;
  logic [31:0] exp_next;
  logic [31:0] m_pc;
  bit          m_v;
  bit          last_redir;
  bit          last_stall;
  int          n_deliv = 0;
  logic        seen_v;
  logic        seen_req;
  logic [31:0] seen_pc;
  logic [31:0] seen_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    exp_fetch  = 32'h0;
    exp_next   = 32'h0;
    m_v        = 1'b0;
    m_pc       = 32'h0;
    last_redir = 1'b0;
    last_stall = 1'b0;
    foreach (mq[i]) mq[i].stale = 1'b0;
  endtask

  task automatic drive_idle();
    i_pc_en       = 1'b1;
    i_IF_ID_stall = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'hDEAD_BEEF;
  endtask

  // One clock cycle, entered and left at a falling edge. st[0]: pc_en low, st[1]: IF/ID stall.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic [1:0] st);
    logic rv;
    bit   any_stale;
    seen_v  = o_ID_valid;
    seen_pc = o_ID_pc;
    if (last_redir) begin
      chk1("id_valid_after_redirect", o_ID_valid, 1'b0);
      chk32("id_inst_after_redirect", o_ID_inst, NOP_INST);
      m_v = 1'b0;
    end else if (last_stall) begin
      chk1("hold_valid", o_ID_valid, m_v);
      if (m_v) begin
        chk32("hold_pc", o_ID_pc, m_pc);
        chk32("hold_inst", o_ID_inst, mem_word(m_pc));
      end else begin
        chk32("hold_bubble_inst", o_ID_inst, NOP_INST);
      end
    end else if (o_ID_valid) begin
      chk32("id_pc_order", o_ID_pc, exp_next);
      chk32("id_inst", o_ID_inst, mem_word(exp_next));
      m_v  = 1'b1;
      m_pc = exp_next;
      dq.push_back(o_ID_pc);
      exp_next = exp_next + 32'd4;
      n_deliv++;
    end else begin
      chk32("bubble_inst", o_ID_inst, NOP_INST);
      m_v = 1'b0;
    end

    any_stale = 1'b0;
    foreach (mq[i]) if (mq[i].stale) any_stale = 1'b1;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    i_redirect    = redir;
    i_redirect_pc = tgt;
    i_pc_en       = ~st[0];
    i_IF_ID_stall = st[1];
    i_imem_gnt    = gnt_en;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
    if (rv) void'(mq.pop_front());
    #1;
    seen_req  = o_imem_req;
    seen_addr = o_imem_addr;
    if (redir) chk1("req_during_redirect", o_imem_req, 1'b0);
    if (any_stale) chk1("req_during_flush", o_imem_req, 1'b0);
    if (o_imem_req && gnt_en) begin
      chk32("fetch_addr", o_imem_addr, exp_fetch);
      mq.push_back('{addr: o_imem_addr, due: cyc + lat, stale: 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      exp_fetch = {tgt[31:2], 2'b00};
      exp_next  = {tgt[31:2], 2'b00};
    end
    last_redir = redir;
    last_stall = |st;
    @(negedge i_clk);
    cyc++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v_h [12];
    logic        r_h [12];
    logic [31:0] p_h [12];
    logic [31:0] a_h [12];

    drive_idle();
    i_rst_n = 1'b1;
    reset_model();
    #2 i_rst_n = 1'b0;
    #1;
    chk1("rst_req", o_imem_req, 1'b0);
    chk32("rst_addr", o_imem_addr, 32'h0);
    chk32("rst_inst", o_ID_inst, 32'h0000_0013);
    chk32("rst_pc", o_ID_pc, 32'h0);
    chk1("rst_valid", o_ID_valid, 1'b0);
    chk32("rst_perf_bubbles", o_perf_bubbles, 32'h0);
    chk32("rst_perf_redirects", o_perf_redirects, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Streaming, grant every cycle, 1-cycle response latency.
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 32'h0, 2'b00);
      v_h[k] = seen_v;
      r_h[k] = seen_req;
      p_h[k] = seen_pc;
      a_h[k] = seen_addr;
    end
    chk1("boot_no_req", r_h[0], 1'b0);
    chk1("first_req_c1", r_h[1], 1'b1);
    chk32("first_addr_c1", a_h[1], 32'h0);
    chk32("second_addr_c2", a_h[2], 32'h4);
    chk1("no_valid_c2", v_h[2], 1'b0);
    chk1("valid_c3", v_h[3], 1'b1);
    chk32("pc_c3", p_h[3], 32'h0);
    chk32("pc_c4", p_h[4], 32'h4);
    chk32("pc_c5", p_h[5], 32'h8);

    // Three-cycle stall fills the buffer and blocks requests.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0, 2'b11);
      r_h[k] = seen_req;
    end
    chk1("stall_full_no_req", r_h[2], 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 2'b00);
    step(1'b0, 32'h0, 2'b01);
    step(1'b0, 32'h0, 2'b10);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 2'b00);

    // Two slow requests in flight, then redirect to 0x100.
    lat = 4;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 2) break;
      step(1'b0, 32'h0, 2'b00);
    end
    chk32("setup_two_outstanding", 32'(mq.size()), 32'd2);
    step(1'b1, 32'h0000_0100, 2'b00);
    dq.delete();
    step(1'b0, 32'h0, 2'b00);
    chk1("redirect_bubble", seen_v, 1'b0);
    for (int k = 0; k < 30; k++) begin
      if (dq.size() > 0) break;
      step(1'b0, 32'h0, 2'b00);
    end
    chk32("first_after_redirect", (dq.size() > 0) ? dq[0] : 32'hFFFF_FFFF, 32'h0000_0100);

    // Redirect coinciding with a grant and a response.
    lat = 1;
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 2'b00);
    step(1'b1, 32'h0000_0200, 2'b00);
    step(1'b0, 32'h0, 2'b00);
    chk1("coincide_bubble", seen_v, 1'b0);
    chk1("coincide_req_next", seen_req, 1'b1);
    chk32("coincide_addr_next", seen_addr, 32'h0000_0200);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 2'b00);

    // Misaligned target near the top of memory wraps to zero.
    step(1'b1, 32'hFFFF_FFFE, 2'b00);
    dq.delete();
    for (int k = 0; k < 20; k++) begin
      if (dq.size() >= 2) break;
      step(1'b0, 32'h0, 2'b00);
    end
    chk32("wrap_first", (dq.size() > 0) ? dq[0] : 32'h1, 32'hFFFF_FFFC);
    chk32("wrap_second", (dq.size() > 1) ? dq[1] : 32'h1, 32'h0000_0000);

    // Asynchronous reset with two requests in flight.
    lat = 4;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 2) break;
      step(1'b0, 32'h0, 2'b00);
    end
    chk32("setup_reset_outstanding", 32'(mq.size()), 32'd2);
    #2 i_rst_n = 1'b0;
    #1;
    chk1("midrst_req", o_imem_req, 1'b0);
    chk32("midrst_addr", o_imem_addr, 32'h0);
    chk32("midrst_inst", o_ID_inst, 32'h0000_0013);
    chk32("midrst_pc", o_ID_pc, 32'h0);
    chk1("midrst_valid", o_ID_valid, 1'b0);
    drive_idle();
    reset_model();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    gnt_en  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 32'h0, 2'b00);
      r_h[k] = seen_req;
      a_h[k] = seen_addr;
      chk1("orphan_response_ignored", seen_v, 1'b0);
    end
    chk1("restart_boot_no_req", r_h[0], 1'b0);
    chk1("restart_req", r_h[1], 1'b1);
    chk32("restart_addr", a_h[1], 32'h0);
    gnt_en = 1'b1;
    lat    = 1;
    dq.delete();
    for (int k = 0; k < 20; k++) begin
      if (dq.size() >= 2) break;
      step(1'b0, 32'h0, 2'b00);
    end
    chk32("restart_first_pc", (dq.size() > 0) ? dq[0] : 32'hFFFF_FFFF, 32'h0);
    chk32("restart_second_pc", (dq.size() > 1) ? dq[1] : 32'hFFFF_FFFF, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
